// File: rtl/uart_rx_pkg.sv
// Shared types and register-map constants for the UART 8N1 receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [3:0] ADDR_RXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_CLEAR  = 4'h2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a combinational head; a pop frees room for a same-cycle push.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM, receive FIFO and
// an Avalon-MM register block with sticky overrun / framing-error flags.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] avms_address_i,
    input  logic       avms_read_i,
    input  logic       avms_write_i,
    input  logic [7:0] avms_writedata_i,
    output logic [7:0] avms_readdata_o,
    input  logic       uart_rxd_i,
    output logic       irq_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int FCW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    logic [1:0]       sync_q;
    logic             rxd_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             overrun;
    logic             frame_err;

    logic             stop_tick;
    logic             stop_ok;
    logic             stop_bad;
    logic             rx_pop;
    logic             clr_overrun;
    logic             clr_frame_err;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    logic [7:0]       status;
    logic             unused_wdata;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], uart_rxd_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shift_q <= {rxd_s, shift_q[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        state <= rxd_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_tick = (state == STOP) && (cnt == BIT_END);
    assign stop_ok   = stop_tick && rxd_s;
    assign stop_bad  = stop_tick && !rxd_s;

    // Bus: read/write are single-cycle strobes with no wait states; readdata is
    // registered, valid the cycle after a read, and held when no read occurs.
    assign rx_pop        = avms_read_i && (avms_address_i == ADDR_RXDATA);
    assign clr_overrun   = avms_write_i && (avms_address_i == ADDR_CLEAR) && avms_writedata_i[STAT_OVERRUN];
    assign clr_frame_err = avms_write_i && (avms_address_i == ADDR_CLEAR) && avms_writedata_i[STAT_FRAME_ERR];
    assign unused_wdata  = ^{avms_writedata_i[7:4], avms_writedata_i[1:0]};

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (stop_ok),
        .pop   (rx_pop),
        .wdata (shift_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A same-cycle pop makes room, so a full FIFO only overruns without one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (stop_ok && fifo_full && !rx_pop) overrun <= 1'b1;
            else if (clr_overrun)                overrun <= 1'b0;
            if (stop_bad)                        frame_err <= 1'b1;
            else if (clr_frame_err)              frame_err <= 1'b0;
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_NOT_EMPTY] = !fifo_empty;
        status[STAT_FULL]      = fifo_full;
        status[STAT_OVERRUN]   = overrun;
        status[STAT_FRAME_ERR] = frame_err;
        status[7:STAT_COUNT_LSB] = 4'(fifo_count);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            avms_readdata_o <= 8'h00;
        end else if (avms_read_i) begin
            case (avms_address_i)
                ADDR_RXDATA: avms_readdata_o <= fifo_empty ? 8'h00 : fifo_rdata;
                ADDR_STATUS: avms_readdata_o <= status;
                default:     avms_readdata_o <= 8'h00;
            endcase
        end
    end

    assign irq_o = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit: frames, glitches,
// framing errors, overrun, mid-frame reset and pop/push collision.
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] address = '0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
    logic       rxd = 1'b1;
    logic       irq;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[7];

    uart_rx_core #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .avms_address_i   (address),
        .avms_read_i      (read),
        .avms_write_i     (write),
        .avms_writedata_i (writedata),
        .avms_readdata_o  (readdata),
        .uart_rxd_i       (rxd),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Start bit plus eight data bits; leaves the line at bit 7.
    task automatic send_data(input logic [7:0] b);
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(16);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_data(b);
        rxd = 1'b1;
        tick(16);
    endtask

    initial begin
        vecs[0] = '{ADDR_STATUS, 8'h47, "t4_status_full_overrun"};
        vecs[1] = '{ADDR_RXDATA, 8'h01, "t4_rx0"};
        vecs[2] = '{ADDR_RXDATA, 8'h02, "t4_rx1"};
        vecs[3] = '{ADDR_RXDATA, 8'h03, "t4_rx2"};
        vecs[4] = '{ADDR_RXDATA, 8'h04, "t4_rx3"};
        vecs[5] = '{ADDR_RXDATA, 8'h00, "t4_rx_empty"};
        vecs[6] = '{ADDR_STATUS, 8'h04, "t4_status_overrun"};

        tick(3);
        rst = 1'b0;
        check("reset_readdata", readdata, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        read_check(ADDR_STATUS, 8'h00, "reset_status");
        read_check(4'h7, 8'h00, "unmapped_read");
        tick(4);

        // 1: 0x55, with exact stop-sample timing of irq
        send_data(8'h55);
        rxd = 1'b1;
        tick(10);
        check("t1_irq_before_stop", {7'd0, irq}, 8'h00);
        tick(1);
        check("t1_irq_after_stop", {7'd0, irq}, 8'h01);
        tick(5);
        read_check(ADDR_STATUS, 8'h11, "t1_status");
        read_check(ADDR_RXDATA, 8'h55, "t1_rxdata");
        read_check(ADDR_STATUS, 8'h00, "t1_status_after");
        check("t1_irq_cleared", {7'd0, irq}, 8'h00);
        tick(3);
        check("t1_readdata_held", readdata, 8'h00);

        // 2: short low glitch
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(40);
        read_check(ADDR_STATUS, 8'h00, "t2_glitch_status");

        // 3: framing error with a held break
        send_data(8'hA5);
        rxd = 1'b0;
        tick(40);
        rxd = 1'b1;
        tick(40);
        read_check(ADDR_STATUS, 8'h08, "t3_frame_err");
        bus_write(ADDR_CLEAR, 8'h08);
        read_check(ADDR_STATUS, 8'h00, "t3_after_clear");

        // 4: overrun, table-driven drain
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        tick(4);
        for (int i = 0; i < 7; i++) read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);

        // 5: reset mid-frame clears FIFO, flags and readdata
        send_byte(8'h77);
        tick(4);
        read_check(ADDR_STATUS, 8'h15, "t5_pre_reset_status");
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1;
            tick(16);
        end
        rxd = 1'b0;
        tick(8);
        rst = 1'b1;
        rxd = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_reset_readdata", readdata, 8'h00);
        check("t5_reset_irq", {7'd0, irq}, 8'h00);
        read_check(ADDR_STATUS, 8'h00, "t5_reset_status");
        tick(32);
        send_byte(8'h3C);
        tick(4);
        read_check(ADDR_STATUS, 8'h11, "t5_status");
        read_check(ADDR_RXDATA, 8'h3C, "t5_rxdata");

        // 6: pop lands on the same edge as the stop-bit push into a full FIFO
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        tick(4);
        read_check(ADDR_STATUS, 8'h43, "t6_full");
        send_data(8'h14);
        rxd = 1'b1;
        tick(10);
        address = ADDR_RXDATA;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
        check("t6_pop_head", readdata, 8'h10);
        tick(8);
        read_check(ADDR_STATUS, 8'h43, "t6_no_overrun");
        for (int i = 0; i < 4; i++) read_check(ADDR_RXDATA, 8'h11 + 8'(i), "t6_drain");
        read_check(ADDR_STATUS, 8'h00, "t6_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
